// File: rtl/drp_reconf_seq.sv
// DRP reconfiguration sequencer: holds the PLL in reset, read-modify-writes each table entry, then waits for lock.
// Optional readback verify of every write is enabled by defining DRP_READBACK_VERIFY_EN.
module drp_reconf_seq #(
  parameter int NUM_ENTRIES  = 23,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD     = 4
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [1:0]  ERR_CODE,
  output logic [4:0]  TBL_IDX,
  input  logic [38:0] TBL_ENTRY,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HOLD      = 4'd1;
  localparam logic [3:0] S_RD        = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_WR        = 4'd4;
  localparam logic [3:0] S_WR_WAIT   = 4'd5;
  localparam logic [3:0] S_NEXT      = 4'd6;
  localparam logic [3:0] S_RELEASE   = 4'd7;
  localparam logic [3:0] S_LOCK_WAIT = 4'd8;
`ifdef DRP_READBACK_VERIFY_EN
  localparam logic [3:0] S_VRD       = 4'd9;
  localparam logic [3:0] S_VRD_WAIT  = 4'd10;
`endif

  localparam logic [15:0] HOLD_LIMIT = 16'(RST_HOLD - 1);
  localparam logic [15:0] DRDY_LIMIT = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_TIMEOUT - 1);
  localparam logic [4:0]  LAST_IDX   = 5'(NUM_ENTRIES - 1);

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_DRDY   = 2'b01;
  localparam logic [1:0] ERR_LOCK   = 2'b10;
`ifdef DRP_READBACK_VERIFY_EN
  localparam logic [1:0] ERR_VERIFY = 2'b11;
`endif

  logic [3:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [4:0]  tbl_idx_q, tbl_idx_d;
  logic [6:0]  daddr_q, daddr_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic [15:0] di_q, di_d;
  logic        pll_rst_q, pll_rst_d;

  logic [6:0]  entry_addr_s;
  logic [15:0] entry_mask_s;
  logic [15:0] entry_data_s;
  logic [15:0] merged_s;
  logic [15:0] cnt_inc_s;
  logic        drdy_ok_s;
  logic        abort_s;
  logic [1:0]  abort_code_s;

  assign entry_addr_s = TBL_ENTRY[38:32];
  assign entry_mask_s = TBL_ENTRY[31:16];
  assign entry_data_s = TBL_ENTRY[15:0];
  // Mask bit set keeps the bit currently held in the DRP register.
  assign merged_s     = (DO & entry_mask_s) | (entry_data_s & ~entry_mask_s);
  assign cnt_inc_s    = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
  // DEN is driven during the first wait cycle, so a response can only be legal one cycle later.
  assign drdy_ok_s    = DRDY & ~den_q;

  // Next-state and output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    err_code_d   = err_code_q;
    tbl_idx_d    = tbl_idx_q;
    daddr_d      = daddr_q;
    den_d        = 1'b0;
    dwe_d        = 1'b0;
    di_d         = di_q;
    pll_rst_d    = pll_rst_q;
    abort_s      = 1'b0;
    abort_code_s = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (START && !done_q && !error_q) begin
          busy_d     = 1'b1;
          pll_rst_d  = 1'b1;
          tbl_idx_d  = 5'd0;
          err_code_d = ERR_NONE;
          cnt_d      = 16'd0;
          state_d    = S_HOLD;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q >= HOLD_LIMIT) begin
          state_d = S_RD;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      S_RD: begin
        den_d   = 1'b1;
        dwe_d   = 1'b0;
        daddr_d = entry_addr_s;
        cnt_d   = 16'd0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drdy_ok_s) begin
          di_d    = merged_s;
          state_d = S_WR;
        end else if (cnt_q >= DRDY_LIMIT) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_DRDY;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_WR: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        cnt_d   = 16'd0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (drdy_ok_s) begin
`ifdef DRP_READBACK_VERIFY_EN
          state_d = S_VRD;
`else
          state_d = S_NEXT;
`endif
        end else if (cnt_q >= DRDY_LIMIT) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_DRDY;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
`ifdef DRP_READBACK_VERIFY_EN
      S_VRD: begin
        den_d   = 1'b1;
        dwe_d   = 1'b0;
        cnt_d   = 16'd0;
        state_d = S_VRD_WAIT;
      end
      S_VRD_WAIT: begin
        if (drdy_ok_s) begin
          if (DO != di_q) begin
            abort_s      = 1'b1;
            abort_code_s = ERR_VERIFY;
          end else begin
            state_d = S_NEXT;
          end
        end else if (cnt_q >= DRDY_LIMIT) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_DRDY;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
`endif
      S_NEXT: begin
        if (tbl_idx_q >= LAST_IDX) begin
          state_d = S_RELEASE;
        end else begin
          tbl_idx_d = tbl_idx_q + 5'd1;
          state_d   = S_RD;
        end
      end
      S_RELEASE: begin
        pll_rst_d = 1'b0;
        cnt_d     = 16'd0;
        state_d   = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (LOCKED) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q >= LOCK_LIMIT) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_LOCK;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // An abort leaves PLL_RST untouched; only a later RELEASE clears it.
    if (abort_s) begin
      error_d    = 1'b1;
      busy_d     = 1'b0;
      err_code_d = abort_code_s;
      state_d    = S_IDLE;
    end else begin
      error_d    = error_d;
    end
  end

  // State and output registers.
  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
      tbl_idx_q  <= 5'd0;
      daddr_q    <= 7'd0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      di_q       <= 16'd0;
      pll_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      tbl_idx_q  <= tbl_idx_d;
      daddr_q    <= daddr_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      di_q       <= di_d;
      pll_rst_q  <= pll_rst_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERROR    = error_q;
  assign ERR_CODE = err_code_q;
  assign TBL_IDX  = tbl_idx_q;
  assign DADDR    = daddr_q;
  assign DEN      = den_q;
  assign DWE      = dwe_q;
  assign DI       = di_q;
  assign PLL_RST  = pll_rst_q;

endmodule

// File: tb/tb_drp_reconf_seq.sv
// Directed bench for drp_reconf_seq with a behavioural DRP responder and a write scoreboard.
module tb_drp_reconf_seq;

  logic        DCLK = 1'b0;
  logic        RST;
  logic        START;
  logic        BUSY, DONE, ERROR;
  logic [1:0]  ERR_CODE;
  logic [4:0]  TBL_IDX;
  logic [38:0] TBL_ENTRY;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;
  logic        PLL_RST;
  logic        LOCKED;

`ifdef DRP_READBACK_VERIFY_EN
  localparam int EXP_DEN = 9;
`else
  localparam int EXP_DEN = 6;
`endif

  drp_reconf_seq #(
    .NUM_ENTRIES(3), .DRDY_TIMEOUT(64), .LOCK_TIMEOUT(100), .RST_HOLD(4)
  ) dut (
    .DCLK(DCLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .ERR_CODE(ERR_CODE), .TBL_IDX(TBL_IDX), .TBL_ENTRY(TBL_ENTRY), .DADDR(DADDR),
    .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY), .PLL_RST(PLL_RST), .LOCKED(LOCKED)
  );

  always #5 DCLK = ~DCLK;

  logic [38:0] tbl [0:2];
  assign TBL_ENTRY = (TBL_IDX < 5'd3) ? tbl[TBL_IDX[1:0]] : 39'd0;

  // Responder configuration, written only by the stimulus block.
  logic [15:0] preload [0:127];
  int          lat;
  int          resp_limit;
  int          corrupt_at;
  logic        mon_clr;

  // Responder state and statistics, written only by the responder block.
  logic [15:0] regs [0:127];
  logic [15:0] rd_val;
  int          pend;
  int          den_count;
  int          acc_n;
  int          wr_n;
  logic        overlap;
  logic        pll_low;
  logic        busy_acc;
  logic [6:0]  wr_addr [0:15];
  logic [15:0] wr_data [0:15];

  typedef struct { logic [6:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];

  int vectors;
  int miscompares;

  always @(posedge DCLK) begin
    if (mon_clr) begin
      for (int i = 0; i < 128; i++) regs[i] <= preload[i];
      pend <= 0; DRDY <= 1'b0; DO <= 16'h0000; den_count <= 0; acc_n <= 0;
      wr_n <= 0; overlap <= 1'b0; pll_low <= 1'b0; busy_acc <= 1'b0; rd_val <= 16'h0000;
    end else begin
      DRDY <= 1'b0;
      if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          DRDY     <= 1'b1;
          DO       <= rd_val;
          busy_acc <= 1'b0;
        end
      end
      if (DEN) begin
        den_count <= den_count + 1;
        acc_n     <= acc_n + 1;
        if (busy_acc) overlap <= 1'b1;
        busy_acc  <= 1'b1;
        if (!PLL_RST) pll_low <= 1'b1;
        if (acc_n < resp_limit) pend <= lat;
        if (DWE) begin
          regs[DADDR] <= DI;
          rd_val      <= DI;
          if (wr_n < 16) begin
            wr_addr[wr_n[3:0]] <= DADDR;
            wr_data[wr_n[3:0]] <= DI;
          end
          wr_n <= wr_n + 1;
        end else begin
          rd_val <= (acc_n == corrupt_at) ? (regs[DADDR] ^ 16'h0001) : regs[DADDR];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input string tag, input int which, input int limit);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge DCLK);
      n++;
      case (which)
        0: hit = DONE;
        1: hit = ERROR;
        2: hit = !PLL_RST;
        3: hit = DEN;
        default: hit = DEN && DWE && (TBL_IDX == 5'd1);
      endcase
    end
    check({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic clr_stats();
    mon_clr = 1'b1;
    @(negedge DCLK);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge DCLK);
    START = 1'b0;
  endtask

  initial begin
    int n;
    wr_t e;
    vectors = 0; miscompares = 0;
    RST = 1'b1; START = 1'b0; LOCKED = 1'b0; mon_clr = 1'b0;
    lat = 2; resp_limit = 1000; corrupt_at = 999;
    for (int i = 0; i < 128; i++) preload[i] = 16'h0000;
    preload[8'h08] = 16'hFFFF;
    preload[8'h10] = 16'hABCD;
    preload[8'h21] = 16'h1234;
    tbl[0] = {7'h08, 16'h1000, 16'h0041};
    tbl[1] = {7'h10, 16'hFFFF, 16'h1234};
    tbl[2] = {7'h21, 16'h00FF, 16'h5A5A};

    repeat (3) @(negedge DCLK);
    check("reset_outputs", {BUSY, DONE, ERROR, ERR_CODE, TBL_IDX, DADDR, DEN, DWE, DI, PLL_RST}, 32'd0);
    RST = 1'b0;
    clr_stats();

    // Full sequence with scoreboarded read-modify-writes
    exp_q.push_back('{a: 7'h08, d: 16'h1041});
    exp_q.push_back('{a: 7'h10, d: 16'hABCD});
    exp_q.push_back('{a: 7'h21, d: 16'h5A34});
    pulse_start();
    check("busy_after_start", 32'(BUSY), 32'd1);
    check("pll_rst_after_start", 32'(PLL_RST), 32'd1);
    check("idx_after_start", 32'(TBL_IDX), 32'd0);
    wait_for("release", 2, 1000);
    check("den_count", 32'(den_count), 32'(EXP_DEN));
    check("den_overlap", 32'(overlap), 32'd0);
    check("pll_rst_low_during_access", 32'(pll_low), 32'd0);
    check("write_count", 32'(wr_n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      check($sformatf("wr%0d_addr", i), 32'(wr_addr[i]), 32'(e.a));
      check($sformatf("wr%0d_data", i), 32'(wr_data[i]), 32'(e.d));
    end
    check("busy_before_lock", 32'(BUSY), 32'd1);
    repeat (3) @(negedge DCLK);
    LOCKED = 1'b1;
    wait_for("done", 0, 50);
    check("done_err_code", 32'(ERR_CODE), 32'd0);
    check("done_busy", 32'(BUSY), 32'd0);
    START = 1'b1;
    @(negedge DCLK);
    START = 1'b0;
    check("done_one_cycle", 32'(DONE), 32'd0);
    check("start_with_done_ignored", 32'(BUSY), 32'd0);
    check("pll_rst_after_done", 32'(PLL_RST), 32'd0);
    LOCKED = 1'b0;

    // DRDY never returned
    resp_limit = 0;
    clr_stats();
    pulse_start();
    wait_for("first_den", 3, 100);
    n = 0;
    while (!ERROR && n < 200) begin
      @(negedge DCLK);
      n++;
    end
    check("drdy_timeout_cycles", 32'(n), 32'd64);
    check("drdy_timeout_code", 32'(ERR_CODE), 32'd1);
    check("drdy_timeout_pll_rst", 32'(PLL_RST), 32'd1);
    check("drdy_timeout_busy", 32'(BUSY), 32'd0);
    repeat (20) @(negedge DCLK);
    check("drdy_timeout_den_count", 32'(den_count), 32'd1);
    check("error_pulse_ended", 32'(ERROR), 32'd0);
    check("err_code_holds", 32'(ERR_CODE), 32'd1);

    // LOCKED never rises
    resp_limit = 1000;
    clr_stats();
    pulse_start();
    wait_for("release2", 2, 1000);
    n = 0;
    while (!ERROR && n < 300) begin
      @(negedge DCLK);
      n++;
    end
    check("lock_timeout_cycles", 32'(n), 32'd100);
    check("lock_timeout_code", 32'(ERR_CODE), 32'd2);

    // Asynchronous reset during WR_WAIT of entry 1, then restart
    LOCKED = 1'b1;
    clr_stats();
    pulse_start();
    check("err_code_cleared_by_start", 32'(ERR_CODE), 32'd0);
    wait_for("entry1_write", 4, 500);
    #2;
    RST = 1'b1;
    #1;
    check("async_reset_outputs", {BUSY, DONE, ERROR, ERR_CODE, TBL_IDX, DADDR, DEN, DWE, DI, PLL_RST}, 32'd0);
    @(negedge DCLK);
    RST = 1'b0;
    clr_stats();
    pulse_start();
    wait_for("restart_den", 3, 100);
    check("restart_idx", 32'(TBL_IDX), 32'd0);
    check("restart_addr", 32'(DADDR), 32'h08);
    wait_for("restart_done", 0, 1000);

`ifdef DRP_READBACK_VERIFY_EN
    // Readback corrupted on the verify read of entry 0
    LOCKED = 1'b0;
    corrupt_at = 2;
    clr_stats();
    pulse_start();
    wait_for("verify_error", 1, 500);
    check("verify_code", 32'(ERR_CODE), 32'd3);
    check("verify_den_count", 32'(den_count), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drp_reconf_seq.md
Name: drp_reconf_seq

Overview:
- Sequences a complete dynamic reconfiguration of the PLL/MMCM model through its DRP port.
- On START it holds the PLL in reset and walks a table of (address, mask, data) entries, doing one read-modify-write per entry. It then releases reset and waits for LOCKED.
- Sits between user logic / the table ROM and the DRP slave (dyn_reconf) in the PLL top level.

Parameters:
- NUM_ENTRIES, 23, number of table entries to process (1..32)
- DRDY_TIMEOUT, 64, DCLK cycles to wait for DRDY before aborting
- LOCK_TIMEOUT, 65535, DCLK cycles to wait for LOCKED after PLL reset release
- RST_HOLD, 4, DCLK cycles PLL_RST is held high before the first DRP access

Ports:
- DCLK  in  1  DRP clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  begin a reconfiguration; sampled in IDLE only
- BUSY  out  1  high from the START cycle until DONE or ERROR
- DONE  out  1  one-cycle pulse on successful lock
- ERROR  out  1  one-cycle pulse on abort
- ERR_CODE  out  2  01 DRDY timeout, 10 lock timeout, 11 verify mismatch; holds until next START
- TBL_IDX  out  5  current table index
- TBL_ENTRY  in  39  combinational table data for TBL_IDX: [38:32] address, [31:16] mask, [15:0] data
- DADDR  out  7  DRP address
- DEN  out  1  DRP enable, one-cycle pulse
- DWE  out  1  DRP write enable, valid with DEN
- DI  out  16  DRP write data
- DO  in  16  DRP read data
- DRDY  in  1  DRP ready
- PLL_RST  out  1  reset to the PLL
- LOCKED  in  1  PLL lock indicator

Behaviour:
- Reset values: all outputs 0; ERR_CODE 00; state IDLE.
- States: IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, NEXT, RELEASE, LOCK_WAIT.
- IDLE: on START=1, set BUSY=1, PLL_RST=1, TBL_IDX=0, ERR_CODE=00, go to HOLD.
- HOLD: count RST_HOLD cycles, then go to RD.
- RD: DEN=1, DWE=0, DADDR=TBL_ENTRY[38:32] for exactly one cycle, then go to RD_WAIT.
- RD_WAIT:
  - DRDY is first sampled on the cycle after the DEN pulse.
  - On DRDY=1, capture DI = (DO & mask) | (data & ~mask). Mask bit 1 means preserve the current value.
  - Then go to WR.
- WR: DEN=1, DWE=1, same DADDR, DI as captured, for one cycle, then go to WR_WAIT.
- WR_WAIT: on DRDY=1 go to NEXT.
- NEXT:
  - If TBL_IDX == NUM_ENTRIES-1, go to RELEASE.
  - Otherwise increment TBL_IDX and go to RD.
  - TBL_IDX never wraps.
- RELEASE: PLL_RST=0, clear the counter, go to LOCK_WAIT.
- LOCK_WAIT: when LOCKED=1, pulse DONE for one cycle, BUSY=0, return to IDLE.
- Timeouts:
  - In RD_WAIT / WR_WAIT, a per-access counter reaching DRDY_TIMEOUT gives ERR_CODE=01.
  - In LOCK_WAIT, a counter reaching LOCK_TIMEOUT gives ERR_CODE=10.
  - Both counters are 16 bits and saturate.
- On any error:
  - Pulse ERROR, BUSY=0, go to IDLE.
  - PLL_RST stays 1, so the PLL is left in reset after an abort.
  - PLL_RST clears only on the next successful RELEASE.
- DRDY while not in a WAIT state is ignored. LOCKED outside LOCK_WAIT is ignored.
- START while BUSY is ignored. START and DONE/ERROR in the same cycle: the new START is ignored.
- Every access sees exactly one DEN cycle; DEN is never asserted while an access is outstanding.
- RST mid-sequence: everything returns to reset values immediately, including PLL_RST=0. No DRP access continues after RST.
- Total latency with DRDY returning in d cycles, without verify: RST_HOLD + NUM_ENTRIES*(5+2d) + lock time + 1 cycles.

Optional Feature:
- Macro: DRP_READBACK_VERIFY_EN.
- Defined:
  - After WR_WAIT, add states VRD and VRD_WAIT: one read of the same address.
  - Compare DO with DI. Mismatch gives ERR_CODE=11, ERROR pulse, abort as above. Match goes to NEXT.
  - VRD_WAIT uses the DRDY timeout.
- Not defined: WR_WAIT goes directly to NEXT; ERR_CODE 11 is never produced.

Test Plan:
- Setup: NUM_ENTRIES=3; entry0 {0x08, 0x1000, 0x0041}; DRP register 0x08 preloaded 0xFFFF; START pulsed.
  -> Write of 0x1041 to 0x08, PLL_RST high for the whole sequence, 6 DEN pulses total, DONE once LOCKED rises, BUSY low after.
- Mask 0xFFFF, data 0x1234 on a register holding 0xABCD.
  -> DI=0xABCD written back unchanged.
- Responder never asserts DRDY after the first read, DRDY_TIMEOUT=64.
  -> ERROR 64 cycles after RD_WAIT entry, ERR_CODE=01, PLL_RST stays 1, no further DEN.
- LOCKED held 0, LOCK_TIMEOUT=100.
  -> ERROR with ERR_CODE=10 100 cycles after PLL_RST falls.
- RST asserted during WR_WAIT of entry 1.
  -> All outputs 0 asynchronously. A subsequent START restarts at TBL_IDX=0.
- DRP_READBACK_VERIFY_EN defined, responder corrupts bit 0 on readback.
  -> ERR_CODE=11 after entry 0, 3 DEN pulses total.
